// File: rtl/ddr3_init_refresh.sv
// DDR3 power-up sequencer and periodic refresh arbiter in front of a DFI command port.
// Latency: one cycle from decision to dfi pins, because all dfi outputs are registered.
// Backpressure: ctl_ready_o is high only in IDLE when no refresh is being granted.
module ddr3_init_refresh #(
  parameter int          DDR_ROW_BITS = 13,
  parameter int          CYC_RESET    = 40000,
  parameter int          CYC_WAKE     = 100000,
  parameter int          CYC_TXPR     = 12,
  parameter int          CYC_MRD      = 4,
  parameter int          CYC_MOD      = 12,
  parameter int          CYC_ZQINIT   = 512,
  parameter int          CYC_REFI     = 780,
  parameter int          CYC_RFC      = 11,
  parameter int          REF_POSTPONE = 8,
  parameter logic [12:0] MR0          = 13'h0000,
  parameter logic [12:0] MR1          = 13'h0000,
  parameter logic [12:0] MR2          = 13'h0000,
  parameter logic [12:0] MR3          = 13'h0000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    ctl_valid_i,
  output logic                    ctl_ready_o,
  input  logic [2:0]              ctl_cmd_i,
  input  logic [2:0]              ctl_ba_i,
  input  logic [DDR_ROW_BITS-1:0] ctl_adr_i,
  output logic                    ref_req_o,
  output logic                    ref_urgent_o,
  input  logic                    ref_gnt_i,
  output logic                    ref_overrun_o,
  output logic                    init_done_o,
  output logic                    dfi_rst_no,
  output logic                    dfi_cke_o,
  output logic                    dfi_cs_no,
  output logic                    dfi_ras_no,
  output logic                    dfi_cas_no,
  output logic                    dfi_we_no,
  output logic                    dfi_odt_o,
  output logic [2:0]              dfi_bank_o,
  output logic [DDR_ROW_BITS-1:0] dfi_addr_o
);

  localparam logic [3:0] S_RESET = 4'd0, S_WAKE = 4'd1, S_CKE  = 4'd2, S_MR2  = 4'd3,
                         S_MR3   = 4'd4, S_MR1  = 4'd5, S_MR0  = 4'd6, S_ZQCL = 4'd7,
                         S_IDLE  = 4'd8, S_REFR = 4'd9;

  localparam logic [2:0] CMD_NOP = 3'b111, CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_ZQCL = 3'b110;
  localparam logic [DDR_ROW_BITS-1:0] ZQ_ADDR = DDR_ROW_BITS'(1) << 10;

  logic [3:0]              state, nxt_state;
  logic [31:0]             cnt, nxt_cnt, refi_cnt;
  logic [3:0]              pending;
  logic                    cnt_zero, tick, ref_go;
  logic                    o_rst_n, o_cke, o_cs_n;
  logic [2:0]              o_cmd, o_ba;
  logic [DDR_ROW_BITS-1:0] o_addr;

  assign cnt_zero      = (cnt == 32'd0);
  assign tick          = init_done_o && (refi_cnt == 32'd0);
  assign ref_req_o     = (pending != 4'd0) && (state == S_IDLE);
  assign ref_urgent_o  = (pending == 4'(REF_POSTPONE));
  assign ref_go        = ref_gnt_i && ref_req_o;
  assign ctl_ready_o   = (state == S_IDLE) && !ref_go;

  // Next state, dwell counter and the command decided for the next pin cycle.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt - 32'd1;
    o_rst_n   = 1'b1;
    o_cke     = 1'b1;
    o_cs_n    = 1'b0;
    o_cmd     = CMD_NOP;
    o_ba      = 3'd0;
    o_addr    = '0;
    case (state)
      S_RESET: begin
        o_rst_n = 1'b0;
        o_cke   = 1'b0;
        o_cs_n  = 1'b1;
        if (cnt_zero) begin nxt_state = S_WAKE; nxt_cnt = 32'(CYC_WAKE - 1); end
      end
      S_WAKE: begin
        o_cke  = 1'b0;
        o_cs_n = 1'b1;
        if (cnt_zero) begin nxt_state = S_CKE; nxt_cnt = 32'(CYC_TXPR - 1); end
      end
      S_CKE: begin
        if (cnt_zero) begin nxt_state = S_MR2; nxt_cnt = 32'(CYC_MRD - 1); end
      end
      S_MR2: begin
        if (cnt == 32'(CYC_MRD - 1)) begin o_cmd = CMD_MRS; o_ba = 3'd2; o_addr = DDR_ROW_BITS'(MR2); end
        if (cnt_zero) begin nxt_state = S_MR3; nxt_cnt = 32'(CYC_MRD - 1); end
      end
      S_MR3: begin
        if (cnt == 32'(CYC_MRD - 1)) begin o_cmd = CMD_MRS; o_ba = 3'd3; o_addr = DDR_ROW_BITS'(MR3); end
        if (cnt_zero) begin nxt_state = S_MR1; nxt_cnt = 32'(CYC_MRD - 1); end
      end
      S_MR1: begin
        if (cnt == 32'(CYC_MRD - 1)) begin o_cmd = CMD_MRS; o_ba = 3'd1; o_addr = DDR_ROW_BITS'(MR1); end
        if (cnt_zero) begin nxt_state = S_MR0; nxt_cnt = 32'(CYC_MOD - 1); end
      end
      S_MR0: begin
        if (cnt == 32'(CYC_MOD - 1)) begin o_cmd = CMD_MRS; o_ba = 3'd0; o_addr = DDR_ROW_BITS'(MR0); end
        // ZQCL dwells one issue cycle plus CYC_ZQINIT NOP cycles.
        if (cnt_zero) begin nxt_state = S_ZQCL; nxt_cnt = 32'(CYC_ZQINIT); end
      end
      S_ZQCL: begin
        if (cnt == 32'(CYC_ZQINIT)) begin o_cmd = CMD_ZQCL; o_addr = ZQ_ADDR; end
        if (cnt_zero) begin nxt_state = S_IDLE; nxt_cnt = 32'd0; end
      end
      S_IDLE: begin
        nxt_cnt = 32'd0;
        if (ref_go) begin
          // REF is decided in the grant cycle; REFR then covers the remaining tRFC-1 NOPs.
          o_cmd     = CMD_REF;
          nxt_state = S_REFR;
          nxt_cnt   = 32'(CYC_RFC - 2);
        end else if (ctl_valid_i) begin
          o_cmd  = ctl_cmd_i;
          o_ba   = ctl_ba_i;
          o_addr = ctl_adr_i;
        end
      end
      S_REFR: begin
        if (cnt_zero) begin nxt_state = S_IDLE; nxt_cnt = 32'd0; end
      end
      default: begin
        nxt_state = S_RESET;
        nxt_cnt   = 32'(CYC_RESET - 1);
      end
    endcase
  end

  // Sequencer state, dwell counter and sticky init-done flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_RESET;
      cnt         <= 32'(CYC_RESET - 1);
      init_done_o <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (state == S_ZQCL && cnt_zero) init_done_o <= 1'b1;
    end
  end

  // Refresh interval timer and pending-refresh bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      refi_cnt      <= 32'(CYC_REFI - 1);
      pending       <= 4'd0;
      ref_overrun_o <= 1'b0;
    end else begin
      if (init_done_o) refi_cnt <= (refi_cnt == 32'd0) ? 32'(CYC_REFI - 1) : refi_cnt - 32'd1;
      if (tick && !ref_go) begin
        if (pending == 4'(REF_POSTPONE)) ref_overrun_o <= 1'b1;
        else                             pending       <= pending + 4'd1;
      end else if (!tick && ref_go) begin
        pending <= pending - 4'd1;
      end
    end
  end

  // DFI pin registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dfi_rst_no <= 1'b0;
      dfi_cke_o  <= 1'b0;
      dfi_cs_no  <= 1'b1;
      dfi_ras_no <= 1'b1;
      dfi_cas_no <= 1'b1;
      dfi_we_no  <= 1'b1;
      dfi_odt_o  <= 1'b0;
      dfi_bank_o <= 3'd0;
      dfi_addr_o <= '0;
    end else begin
      dfi_rst_no <= o_rst_n;
      dfi_cke_o  <= o_cke;
      dfi_cs_no  <= o_cs_n;
      {dfi_ras_no, dfi_cas_no, dfi_we_no} <= o_cmd;
      dfi_odt_o  <= 1'b0;
      dfi_bank_o <= o_ba;
      dfi_addr_o <= o_addr;
    end
  end

endmodule

// File: doc/ddr3_init_refresh.md
DDR3_INIT_REFRESH -- requirements
Module: ddr3_init_refresh

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- DDR_ROW_BITS, 13, address width.
- CYC_RESET, 40000, RESET# low time in cycles.
- CYC_WAKE, 100000, RESET# high to CKE high, in cycles.
- CYC_TXPR, 12, CKE high to first MRS.
- CYC_MRD, 4, MRS to MRS.
- CYC_MOD, 12, final MRS to non-MRS.
- CYC_ZQINIT, 512, ZQCL duration.
- CYC_REFI, 780, refresh interval.
- CYC_RFC, 11, REF to next command.
- REF_POSTPONE, 8, maximum pending refreshes (2..8).
- MR0, MR1, MR2, MR3, 13-bit, mode-register values.

REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clock, in, 1, sole clock.
- reset_n, in, 1, synchronous active-low reset.
- ctl_valid_i, in, 1, controller command valid.
- ctl_ready_o, out, 1, command accepted this cycle.
- ctl_cmd_i, in, 3, {RAS#,CAS#,WE#}.
- ctl_ba_i, in, 3, bank.
- ctl_adr_i, in, DDR_ROW_BITS, address.
- ref_req_o, out, 1, refresh pending.
- ref_urgent_o, out, 1, pending equals REF_POSTPONE.
- ref_gnt_i, in, 1, all banks precharged, issue REF now.
- ref_overrun_o, out, 1, sticky overflow.
- init_done_o, out, 1, init complete.
- dfi_rst_no, dfi_cke_o, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_odt_o, out, 1 each, DFI controls.
- dfi_bank_o, out, 3, bank.
- dfi_addr_o, out, DDR_ROW_BITS, address.

REQ-003 SHALL operate on one clock, with reset synchronous and active-low on reset_n.

Function
REQ-004 SHALL register all dfi_* outputs, giving one-cycle latency from decision to pin.
REQ-005 SHALL drive NOP by default: cs_n=0, {ras,cas,we}_n=111, bank=0, addr=0, odt=0.
REQ-006 SHALL sequence init states through one down-counter:
- RESET: rst_n=0, cke=0, CYC_RESET cycles.
- WAKE: rst_n=1, cke=0, CYC_WAKE cycles.
- CKE: cke=1, NOP, CYC_TXPR cycles.
- MR2, MR3, MR1, MR0: each issues MRS, then NOP.
- ZQCL: ZQCL, then NOP.
- IDLE.
REQ-007 SHALL issue each MRS as a single-cycle command {000} with bank = register index and addr = MRn. The MR2/MR3/MR1 states SHALL last CYC_MRD cycles each; the MR0 state SHALL last CYC_MOD cycles.
REQ-008 SHALL issue ZQCL as a single cycle with {110}, addr[10]=1, then hold NOP for CYC_ZQINIT cycles.
REQ-009 SHALL hold dfi_cs_no=1 in RESET and WAKE.
REQ-010 SHALL raise init_done_o on entry to IDLE and hold it until reset.
REQ-011 SHALL drive ctl_ready_o = (state==IDLE) && !(ref_gnt_i && ref_req_o).
REQ-012 SHALL pass an accepted command (ctl_valid_i && ctl_ready_o) to dfi_* on the next cycle, with cs_n=0. An unaccepted cycle SHALL produce NOP.
REQ-013 SHALL start the refresh-interval counter at init_done. The counter SHALL reload CYC_REFI-1 on reaching zero, and each zero SHALL be a "tick".
REQ-014 SHALL keep a pending counter (0..REF_POSTPONE) with these rules:
- Tick: +1.
- REF issue: -1.
- Both in the same cycle: unchanged.
- Tick at REF_POSTPONE without issue: counter held, ref_overrun_o set sticky.
REQ-015 SHALL drive ref_req_o = (pending!=0) && state==IDLE, and ref_urgent_o = (pending==REF_POSTPONE).
REQ-016 On ref_gnt_i && ref_req_o, SHALL go to REFR. REFR SHALL issue REF {001} on the next cycle, then NOP for CYC_RFC-1 cycles, then return to IDLE.
REQ-017 SHALL ignore ref_gnt_i when ref_req_o=0.
REQ-018 SHALL keep the refresh-interval counter running during REFR.
REQ-019 SHALL keep ctl_ready_o=0 in every state other than IDLE.
REQ-020 SHALL hold dfi_cke_o=1 and dfi_rst_no=1 from CKE onward.

Reset
REQ-021 While reset_n=0 at a clock edge, SHALL set:
- state=RESET and counters reloaded.
- pending=0, ref_overrun_o=0, init_done_o=0.
- dfi_rst_no=0, dfi_cke_o=0, dfi_cs_no=1, other dfi_* = NOP/0.
- ctl_ready_o=0, ref_req_o=0, ref_urgent_o=0.
REQ-022 Reset asserted mid-init or mid-refresh SHALL abort immediately and restart the full init sequence.

Verification (CYC_RESET=4, CYC_WAKE=6, CYC_TXPR=3, CYC_MRD=2, CYC_MOD=3, CYC_ZQINIT=5, CYC_REFI=20, CYC_RFC=4, REF_POSTPONE=2)
REQ-023 Release reset_n -> rst_n rises 4 cycles later; cke rises 6 cycles after that. The bench SHALL check MRS order MR2, MR3, MR1, MR0 (bank 2, 3, 1, 0) spaced 2, 2, 2 cycles, ZQCL 3 cycles after MR0 with addr[10]=1, and init_done_o 5 cycles after ZQCL.
REQ-024 After init, ctl_valid_i with cmd=ACT {011}, ba=5, adr=0x123 -> same-cycle ctl_ready_o=1, and next cycle dfi ras_n=0, cas_n=1, we_n=1, bank=5, addr=0x123.
REQ-025 No grant for 20 cycles -> ref_req_o=1. Then ref_gnt_i -> ctl_ready_o=0 that cycle, REF on dfi next cycle, ctl_ready_o=0 for 4 cycles, pending returns to 0.
REQ-026 No grant for 40 cycles -> ref_urgent_o=1. Tick 60 -> ref_overrun_o=1 and pending stays 2.
REQ-027 ref_gnt_i on the same cycle as a tick with pending=1 -> pending stays 1 and REF is issued.
REQ-028 reset_n=0 during REFR -> next cycle dfi_rst_no=0, dfi_cke_o=0, init_done_o=0, and init repeats per REQ-023.
